// File: rtl/ysyx_24110015_mem_resp.sv
// Memory-side responder: accepts one valid/ready request, waits LATENCY cycles, accesses pmem, holds the response.
// Define MEM_RAND_DELAY_EN to add 0..7 LFSR-chosen extra wait cycles per request.

package ysyx_24110015_pmem_pkg;
    // Simulated physical memory exposing the NPC pmem_read/pmem_write call signatures.
    logic [31:0] pmem [logic [31:0]];
    int unsigned pmem_reads;
    int unsigned pmem_writes;
    logic [31:0] pmem_last_waddr;

    function automatic int pmem_read(input int raddr);
        logic [31:0] a;
        a = raddr;
        pmem_reads = pmem_reads + 1;
        return pmem.exists(a) ? pmem[a] : 32'h0;
    endfunction

    function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] word;
        a = waddr;
        d = wdata;
        word = pmem.exists(a) ? pmem[a] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (wmask[i]) word[8*i +: 8] = d[8*i +: 8];
        pmem[a] = word;
        pmem_writes = pmem_writes + 1;
        pmem_last_waddr = a;
    endfunction
endpackage

module ysyx_24110015_mem_resp #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata
);
    import ysyx_24110015_pmem_pkg::*;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

`ifdef MEM_RAND_DELAY_EN
    localparam int CW = 5;
`else
    localparam int CW = 4;
`endif
    localparam logic [CW-1:0] CNT_BASE = CW'(LATENCY - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_load;
    logic          wen;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
    logic [31:0]   word_addr;

`ifdef MEM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so the extra delay depends on issue timing.
    always_ff @(posedge clk) begin
        if (!rst) lfsr <= 8'h5a;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign cnt_load = CNT_BASE + CW'(lfsr[2:0]);
`else
    assign cnt_load = CNT_BASE;
`endif

    assign req_ready = rst && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign word_addr = {addr[31:2], 2'b00};

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; an in-flight access is dropped before it reaches pmem.
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            wen       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wmask     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wen   <= req_wen;
                        addr  <= req_addr;
                        wdata <= req_wdata;
                        wmask <= req_wmask;
                        cnt   <= cnt_load;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (wen) begin
                            if (wmask != 4'b0) pmem_write(word_addr, wdata, {4'b0, wmask});
                            rsp_rdata <= '0;
                        end else begin
                            rsp_rdata <= pmem_read(word_addr);
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_24110015_mem_resp.sv
// Directed bench for ysyx_24110015_mem_resp: one LATENCY=1 and one LATENCY=4 instance sharing pmem.
// With MEM_RAND_DELAY_EN defined, gap checks become range checks and a repeatability test runs.

module tb_ysyx_24110015_mem_resp;
    import ysyx_24110015_pmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_ready;

    logic        a_req_ready, b_req_ready;
    logic        a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int n_vec;
    int n_bad;

    ysyx_24110015_mem_resp #(.LATENCY(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && !sel),
        .req_ready (a_req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (a_rsp_rdata)
    );

    ysyx_24110015_mem_resp #(.LATENCY(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid && sel),
        .req_ready (b_req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (b_rsp_rdata)
    );

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the selected instance; holds rsp_ready low for 'hold' RESP cycles.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int hold, input logic [31:0] exp,
                       output int gap);
        int lat;
        lat = sel ? 4 : 1;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        rsp_ready = (hold == 0);
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        gap = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && gap < 40) begin
            @(posedge clk);
            gap++;
            @(negedge clk);
        end
        check("rsp_valid_seen", rsp_valid, 1);
`ifdef MEM_RAND_DELAY_EN
        check("gap_range", (gap >= lat) && (gap <= lat + 7), 1);
`else
        check("gap", gap, lat);
`endif
        check("rsp_rdata", rsp_rdata, exp);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, exp);
            check("hold_req_ready", req_ready, 0);
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_addr  = 32'h8000_0000;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int gap;
        int unsigned wc;
        int unsigned rc;
`ifdef MEM_RAND_DELAY_EN
        int gaps [2][100];
`endif
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b0;
        pmem_write(32'h8000_0000, 32'h0000_0413, 8'h0f);
        pmem_write(32'h8000_0100, 32'h1122_3344, 8'h0f);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_req_ready", req_ready, 1);

        // Read 0x8000_0000, LATENCY=1
        rc = pmem_reads;
        txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0000_0413, gap);
        check("read_calls", pmem_reads, rc + 1);

        // Masked write to unaligned address, then read back merged word
        wc = pmem_writes;
        txn(1'b1, 32'h8000_0102, 32'hAABB_CCDD, 4'b1100, 0, 32'h0, gap);
        check("write_calls", pmem_writes, wc + 1);
        check("write_addr", pmem_last_waddr, 32'h8000_0100);

        // Backpressure with an ignored second request
        rc = pmem_reads;
        txn(1'b0, 32'h8000_0100, 32'h0, 4'h0, 5, 32'hAABB_3344, gap);
        check("bp_read_calls", pmem_reads, rc + 1);

        // LATENCY=4, write with empty mask
        sel = 1'b1;
        wc = pmem_writes;
        txn(1'b1, 32'h8000_0300, 32'h1234_5678, 4'b0000, 0, 32'h0, gap);
        check("nomask_write_calls", pmem_writes, wc);

        // Reset during WAIT of a write
        wc = pmem_writes;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0200;
        req_wdata = 32'hDEAD_BEEF;
        req_wmask = 4'hf;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("wait_req_ready", req_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_rsp_rdata", rsp_rdata, 0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_rst_no_write", pmem_writes, wc);
        check("mid_rst_idle_valid", rsp_valid, 0);
        txn(1'b0, 32'h8000_0200, 32'h0, 4'h0, 0, 32'h0, gap);
        sel = 1'b0;

`ifdef MEM_RAND_DELAY_EN
        // Random extra delay: bounded gaps, correct data, repeatable after reset
        for (int run = 0; run < 2; run++) begin
            do_reset();
            for (int i = 0; i < 100; i++) begin
                if (i % 2 == 0) txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0000_0413, gap);
                else            txn(1'b0, 32'h8000_0100, 32'h0, 4'h0, 0, 32'hAABB_3344, gap);
                gaps[run][i] = gap;
            end
        end
        for (int i = 0; i < 100; i++) check("rand_repeat", gaps[1][i], gaps[0][i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
